// File: rtl/cache_bus_arbiter.sv
// Shares one memory bus between the I-cache and D-cache: round-robin request
// grant held across bursts, plus tag-matched steering of line-fill response beats.
module cache_bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS_PER_LINE = 8,
  parameter int unsigned READ_TAG_BIT   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
  input  logic                      i_respack,
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
  input  logic                      d_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      err_unmatched
);

  localparam int unsigned CW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} gnt_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  gnt_state_t               state;
  logic                     rr_favour_d;
  logic                     pending_i, pending_d;
  logic [BUS_TAG_WIDTH-1:0] tag_i, tag_d;
  owner_t                   resp_owner;
  logic [CW-1:0]            beat_cnt;
  logic                     err_q;

  logic                      elig_i, elig_d;
  logic                      match_i, match_d, unmatched;
  owner_t                    route;
  logic                      fwd_cyc;
  logic [BUS_DATA_WIDTH-1:0] fwd_req;
  logic [BUS_TAG_WIDTH-1:0]  fwd_tag;
  logic                      fwd_respack;
  logic                      capture;

  assign elig_i    = i_reqcyc & ~pending_i;
  assign elig_d    = d_reqcyc & ~pending_d;
  assign match_d   = pending_d & (bus_resptag == tag_d);
  assign match_i   = pending_i & (bus_resptag == tag_i);
  assign unmatched = (resp_owner == OWN_NONE) & bus_respcyc & ~match_d & ~match_i;

  // The first beat of a fill is steered in the cycle it matches, before resp_owner registers it.
  always_comb begin
    route = resp_owner;
    if (resp_owner == OWN_NONE && bus_respcyc) begin
      if (match_d)      route = OWN_D;
      else if (match_i) route = OWN_I;
      else              route = OWN_NONE;
    end
  end

  always_comb begin
    fwd_cyc = 1'b0;
    fwd_req = '0;
    fwd_tag = '0;
    case (state)
      GNT_I: begin
        fwd_cyc = i_reqcyc;
        fwd_req = i_req;
        fwd_tag = i_reqtag;
      end
      GNT_D: begin
        fwd_cyc = d_reqcyc;
        fwd_req = d_req;
        fwd_tag = d_reqtag;
      end
      default: ;
    endcase
    case (route)
      OWN_I:   fwd_respack = i_respack;
      OWN_D:   fwd_respack = d_respack;
      default: fwd_respack = unmatched;
    endcase
  end

  assign capture = fwd_cyc & bus_reqack & fwd_tag[READ_TAG_BIT];

  always_comb begin
    bus_reqcyc    = 1'b0;
    bus_req       = '0;
    bus_reqtag    = '0;
    i_reqack      = 1'b0;
    d_reqack      = 1'b0;
    i_respcyc     = 1'b0;
    d_respcyc     = 1'b0;
    i_resp        = '0;
    d_resp        = '0;
    i_resptag     = '0;
    d_resptag     = '0;
    bus_respack   = 1'b0;
    err_unmatched = 1'b0;
    if (reset) begin
      bus_reqcyc    = fwd_cyc;
      bus_req       = fwd_req;
      bus_reqtag    = fwd_tag;
      i_reqack      = (state == GNT_I) & bus_reqack;
      d_reqack      = (state == GNT_D) & bus_reqack;
      i_respcyc     = bus_respcyc & (route == OWN_I);
      d_respcyc     = bus_respcyc & (route == OWN_D);
      i_resp        = bus_resp;
      d_resp        = bus_resp;
      i_resptag     = bus_resptag;
      d_resptag     = bus_resptag;
      bus_respack   = fwd_respack;
      err_unmatched = err_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_favour_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig_d && (rr_favour_d || !elig_i)) state <= GNT_D;
          else if (elig_i)                        state <= GNT_I;
        end
        GNT_I: begin
          if (!i_reqcyc || pending_i) begin
            state       <= elig_d ? GNT_D : IDLE;
            rr_favour_d <= 1'b1;
          end
        end
        GNT_D: begin
          if (!d_reqcyc || pending_d) begin
            state       <= elig_i ? GNT_I : IDLE;
            rr_favour_d <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture is written after completion so a same-cycle new read re-arms pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_i  <= 1'b0;
      pending_d  <= 1'b0;
      tag_i      <= '0;
      tag_d      <= '0;
      resp_owner <= OWN_NONE;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (resp_owner == OWN_NONE && route != OWN_NONE) resp_owner <= route;
      if (route != OWN_NONE && fwd_respack) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt   <= '0;
          resp_owner <= OWN_NONE;
          if (route == OWN_D) pending_d <= 1'b0;
          else                pending_i <= 1'b0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (capture && state == GNT_D) begin
        pending_d <= 1'b1;
        tag_d     <= fwd_tag;
      end
      if (capture && state == GNT_I) begin
        pending_i <= 1'b1;
        tag_i     <= fwd_tag;
      end
      if (unmatched) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single memory bus between the I-cache and D-cache (each speaks the reqcyc/reqack/respcyc/respack bus protocol).
- Grants one client at a time using round-robin, and holds the grant for multi-beat write-back bursts.
- Tracks each client's outstanding line read and steers the response beats back to that client.
- Sits between both cache controllers and the top-level bus ports.

Parameters:
- BUS_DATA_WIDTH, 64, width of the req/resp data bus.
- BUS_TAG_WIDTH, 13, width of the req/resp tags.
- BEATS_PER_LINE, 8, response beats per line fill (power of 2).
- READ_TAG_BIT, 12, position of the reqtag bit that marks a read request (1 = read, 0 = write).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active low.
- i_reqcyc / d_reqcyc  in  1  client request valid.
- i_req / d_req  in  BUS_DATA_WIDTH  client request data/address.
- i_reqtag / d_reqtag  in  BUS_TAG_WIDTH  client request tag.
- i_reqack / d_reqack  out  1  bus_reqack forwarded to the granted client.
- i_respcyc / d_respcyc  out  1  routed response valid.
- i_resp / d_resp  out  BUS_DATA_WIDTH  response data (bus_resp broadcast).
- i_resptag / d_resptag  out  BUS_TAG_WIDTH  response tag (bus_resptag broadcast).
- i_respack / d_respack  in  1  client response ack.
- bus_reqcyc  out  1  request valid to bus.
- bus_req  out  BUS_DATA_WIDTH  request data to bus.
- bus_reqtag  out  BUS_TAG_WIDTH  request tag to bus.
- bus_reqack  in  1  bus request ack.
- bus_respcyc  in  1  bus response valid.
- bus_resp  in  BUS_DATA_WIDTH  bus response data.
- bus_resptag  in  BUS_TAG_WIDTH  bus response tag.
- bus_respack  out  1  response ack to bus.
- err_unmatched  out  1  sticky flag: a response arrived with no owning client.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant state goes to IDLE, round-robin pointer favours D.
  - pending_i/pending_d, tag registers, resp_owner and beat counter are cleared; err_unmatched=0.
  - All outputs are 0 during reset, including mid-burst; clients are responsible for re-issuing.
- Grant FSM states: IDLE, GNT_I, GNT_D.
  - A client is eligible when its reqcyc=1 and its pending flag=0.
  - IDLE: if both are eligible, grant the one favoured by the pointer; if one is eligible, grant it. The transition takes effect next cycle, so there is 1 cycle of latency from reqcyc to the forwarded bus_reqcyc.
  - GNT_x:
    - bus_reqcyc/bus_req/bus_reqtag = x_*, combinationally.
    - x_reqack = bus_reqack; the other client's reqack = 0.
    - The grant is held while x_reqcyc=1, so a write-back header, its data beats and the following read stay on one grant.
  - Leaving GNT_x: when x_reqcyc=0 (or pending_x becomes 1), go to GNT_other if the other client is eligible, else IDLE.
  - The pointer flips to the other client whenever GNT_x is exited.
  - In IDLE, bus_reqcyc=0, bus_req=0, bus_reqtag=0.
- Read capture:
  - Condition: in GNT_x, the cycle bus_reqcyc & bus_reqack & bus_reqtag[READ_TAG_BIT]=1.
  - Action: pending_x<=1 and tag_x<=bus_reqtag.
  - Effect: the client is ineligible for new grants until its fill completes.
- Response routing:
  - While resp_owner=NONE, a bus_respcyc beat is matched against the tags:
    - tag_d match while pending_d: resp_owner<=D.
    - else tag_i match while pending_i: resp_owner<=I.
    - If both match, D wins and I remains pending.
  - The first beat is routed combinationally in the same cycle: x_respcyc = bus_respcyc on the matched client.
  - While resp_owner=x: x_respcyc=bus_respcyc, bus_respack=x_respack; the other client's respcyc=0.
  - The beat counter (log2(BEATS_PER_LINE) bits) increments on each cycle bus_respack=1.
  - When the increment happens at count BEATS_PER_LINE-1: count wraps to 0, resp_owner<=NONE, pending_x<=0.
  - An unmatched bus_respcyc while resp_owner=NONE: bus_respack=1 for that cycle (the beat is dropped) and err_unmatched<=1 (sticky until reset).
- Concurrency:
  - Request granting and response routing are independent.
  - A fill to one client may proceed while the other client holds the request grant.
  - Capture and completion in the same cycle for the same client: completion clears first, then the capture sets pending.
- i_resp/d_resp/i_resptag/d_resptag always mirror the bus inputs.

Test Plan:
- Single D read: d_reqcyc=1, d_reqtag=0x1103, bus_reqack at cycle 3 -> d_reqack pulses in cycle 3, pending_d=1. Then 8 respcyc beats with tag 0x1103 plus d_respack -> d_respcyc high on each beat, i_respcyc=0, pending_d clears after the 8th ack.
- Simultaneous requests after reset -> D granted first. Then D drops reqcyc -> GNT_I the next cycle. A second contention -> I is favoured by the pointer; verify strict alternation over 4 rounds.
- D write-back burst: 1 header beat (tag 0x0103) + 8 data beats + read (0x1103) with reqcyc held, I requesting throughout -> I never granted until d_reqcyc=0. Only the read sets pending_d.
- I fill in progress while D holds the grant and is sending a write-back -> both proceed; beats reach only i_respcyc; bus_req carries d_req.
- Response with tag 0x0ABC, no pending reads -> bus_respack=1 the same cycle, err_unmatched=1 and stays 1.
- Assert reset mid-fill at beat 4 -> all outputs go 0 immediately. After release, a new D read completes normally with the count starting from 0.
